// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the mini CPU: steps T0..T6 per instruction
// and drives every datapath strobe from the present state and the IR opcode.
module control_sequencer #(
  parameter int OP_W = 5
) (
  input  logic            Clock,
  input  logic            clear,
  input  logic            Stop,
  input  logic [31:0]     IR,
  input  logic            CON,
  output logic            PCout,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            Cout,
  output logic            BAOut,
  output logic            Rout,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            ZHighin,
  output logic            Zlowin,
  output logic            Rin,
  output logic            CONin,
  output logic            IncPC,
  output logic            Read,
  output logic            Write,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic [OP_W-1:0] op,
  output logic            Run
);

  typedef enum logic [3:0] {
    RESET, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5'b01100);
  localparam logic [OP_W-1:0] OP_BR   = OP_W'(5'b10010);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(5'b11011);

  state_t          state, state_nx, end_nx;
  logic [OP_W-1:0] opcode;
  logic            is_alu, is_addi, is_br, is_halt;

  // IR is the datapath's own register, so decoding it directly from T3 on
  // still yields Moore outputs.
  assign opcode  = IR[31 -: OP_W];
  assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);
  assign is_addi = (opcode == OP_ADDI);
  assign is_br   = (opcode == OP_BR);
  assign is_halt = (opcode == OP_HALT);

  // Stop only matters at an instruction boundary.
  assign end_nx = Stop ? HALT : T0;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; clear is synchronous and dominates every state.
  always_ff @(posedge Clock) begin
    if (clear) state <= RESET;
    else       state <= state_nx;
  end

  // NOTE: every signal written below gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      RESET: state_nx = T0;
      T0:    state_nx = T1;
      T1:    state_nx = T2;
      T2:    state_nx = T3;
      T3: begin
        if (is_alu || is_addi || is_br) state_nx = T4;
        else if (is_halt)               state_nx = HALT;
        else                            state_nx = end_nx;
      end
      T4:    state_nx = T5;
      T5:    state_nx = is_br ? T6 : end_nx;
      T6:    state_nx = end_nx;
      HALT:  state_nx = HALT;
      default: state_nx = RESET;
    endcase
  end

  always_comb begin
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    Cout  = 1'b0; BAOut    = 1'b0; Rout    = 1'b0;
    MARin = 1'b0; PCin     = 1'b0; MDRin   = 1'b0; IRin  = 1'b0;
    Yin   = 1'b0; ZHighin  = 1'b0; Zlowin  = 1'b0; Rin   = 1'b0;
    CONin = 1'b0;
    IncPC = 1'b0; Read     = 1'b0; Write   = 1'b0;
    Gra   = 1'b0; Grb      = 1'b0; Grc     = 1'b0;
    op    = '0;
    Run   = 1'b1;
    unique case (state)
      RESET: ;
      T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZHighin = 1'b1; Zlowin = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      T3: begin
        if (is_alu) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_addi) begin
          Grb = 1'b1; BAOut = 1'b1; Yin = 1'b1;
        end else if (is_br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end
      end
      T4: begin
        if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; ZHighin = 1'b1; Zlowin = 1'b1; op = opcode;
        end else if (is_addi) begin
          Cout = 1'b1; ZHighin = 1'b1; Zlowin = 1'b1; op = OP_ADD;
        end else if (is_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      T5: begin
        if (is_br) begin
          Cout = 1'b1; ZHighin = 1'b1; Zlowin = 1'b1; op = OP_ADD;
        end else begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      T6: begin
        Zlowout = 1'b1;
        PCin    = CON;
      end
      HALT: Run = 1'b0;
      default: ;
    endcase
  end

endmodule
